// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_ctrl
//  Purpose  : Central sequencing controller for the 5-stage pipeline. Turns
//             EXE-stage hazards (load-use stall, taken branch) into PC,
//             IF/ID and ID/EXE write-enable/flush/next-PC controls.
//             Implements a halt -> drain -> halted -> resume sequence and
//             keeps saturating stall and flush event counters.
//  Ports    : Clk, Clrn (async active-low reset)
//             stall, Branch, EXE_bpc[31:0]  - EXE-stage hazard inputs
//             Halt_Req (level), Resume (pulse) - halt/resume control
//             PC_Wr, PC_Sel, Target[31:0]    - PC controls
//             IF_ID_Wr, ID_EXE_Wr            - pipeline register enables
//             IF_ID_Flush, ID_EXE_Flush      - bubble insertion
//             Halted                         - high in HALTED
//             Stall_Cnt, Flush_Cnt [CNT_W]   - saturating event counters
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             stall,
    input  logic             Branch,
    input  logic [31:0]      EXE_bpc,
    input  logic             Halt_Req,
    input  logic             Resume,
    output logic             PC_Wr,
    output logic             PC_Sel,
    output logic [31:0]      Target,
    output logic             IF_ID_Wr,
    output logic             ID_EXE_Wr,
    output logic             IF_ID_Flush,
    output logic             ID_EXE_Flush,
    output logic             Halted,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_DRAIN   = 2'b01,
        S_HALTED  = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    // Counter counts down to 0, so a load of N-1 yields N drain cycles.
    localparam logic [3:0] c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    // After a branch only the new ID/EXE/MEM contents remain to retire.
    localparam logic [3:0] c_BR_LOAD    = 4'd2;

    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic w_pc_wr, w_pc_sel, w_if_id_wr, w_id_exe_wr;
    logic w_if_id_flush, w_id_exe_flush, w_halted;
    logic w_stall_evt, w_flush_evt;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q     <= S_RUN;
            drain_q     <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state and control outputs. Precedence: stall > Branch > normal.
    // In RUN, Halt_Req/Resume only influence next state, never the enables.
    always_comb begin
        state_d        = state_q;
        drain_d        = drain_q;
        w_pc_wr        = 1'b0;
        w_pc_sel       = 1'b0;
        w_if_id_wr     = 1'b0;
        w_id_exe_wr    = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_exe_flush = 1'b0;
        w_halted       = 1'b0;
        w_stall_evt    = 1'b0;
        w_flush_evt    = 1'b0;

        case (state_q)
            S_RUN, S_DRAIN: begin
                if (stall) begin
                    // Hold everything; Branch is ignored (stale Zero flag)
                    // and the drain counter is frozen.
                    w_stall_evt = 1'b1;
                end else if (Branch) begin
                    w_pc_wr        = 1'b1;
                    w_pc_sel       = 1'b1;
                    w_if_id_wr     = 1'b1;
                    w_id_exe_wr    = 1'b1;
                    w_if_id_flush  = 1'b1;
                    w_id_exe_flush = 1'b1;
                    w_flush_evt    = 1'b1;
                    if (state_q == S_DRAIN || Halt_Req) begin
                        state_d = S_DRAIN;
                        drain_d = c_BR_LOAD;
                    end
                end else if (state_q == S_RUN) begin
                    w_pc_wr     = 1'b1;
                    w_if_id_wr  = 1'b1;
                    w_id_exe_wr = 1'b1;
                    if (Halt_Req) begin
                        state_d = S_DRAIN;
                        drain_d = c_DRAIN_LOAD;
                    end
                end else begin
                    // Draining: stop fetch, keep retiring older stages.
                    w_if_id_flush = 1'b1;
                    w_id_exe_wr   = 1'b1;
                    if (drain_q == 4'd0) begin
                        state_d = S_HALTED;
                    end else begin
                        drain_d = drain_q - 4'd1;
                    end
                end
            end
            S_HALTED: begin
                w_halted = 1'b1;
                if (Resume) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
                drain_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (w_stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (w_flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // While Clrn is low the pipeline registers are held and loaded with
    // bubbles regardless of the (already reset) state.
    assign PC_Wr        = Clrn & w_pc_wr;
    assign PC_Sel       = Clrn & w_pc_sel;
    assign IF_ID_Wr     = Clrn & w_if_id_wr;
    assign ID_EXE_Wr    = Clrn & w_id_exe_wr;
    assign IF_ID_Flush  = ~Clrn | w_if_id_flush;
    assign ID_EXE_Flush = ~Clrn | w_id_exe_flush;
    assign Halted       = Clrn & w_halted;
    assign Target       = EXE_bpc;
    assign Stall_Cnt    = stall_cnt_q;
    assign Flush_Cnt    = flush_cnt_q;

endmodule
`default_nettype wire
